// File: rtl/ibex_pkg.sv
// Shared types for the instruction-memory responder: the response word that travels
// down the latency pipe, plus sizing constants.
package ibex_pkg;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } imem_resp_t;

    localparam int unsigned ImemCntW = 3;

    // Unsigned window check on an already base-relative byte offset.
    function automatic logic imem_in_window(input logic [31:0] offset,
                                            input logic [32:0] win_bytes);
        return {1'b0, offset} < win_bytes;
    endfunction

endpackage

// File: rtl/ibex_imem_resp_pipe.sv
// Fixed-depth shift register carrying instruction responses; depth sets the extra
// latency added after the SRAM read data has been captured.
module ibex_imem_resp_pipe
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  imem_resp_t resp_i,
    output imem_resp_t resp_o
);

    imem_resp_t stage_q [Depth];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= resp_i;
            for (int i = 1; i < int'(Depth); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign resp_o = stage_q[Depth-1];

endmodule

// File: rtl/ibex_imem_responder.sv
// Instruction-fetch responder in front of an external synchronous SRAM: grants fetches,
// flags out-of-window addresses, and returns in-order responses after a fixed latency.
module ibex_imem_responder
    import ibex_pkg::*;
#(
    parameter logic [31:0] MemBase        = 32'h0000_0000,
    parameter int unsigned MemWords       = 4096,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned AddrW         = (MemWords > 1) ? $clog2(MemWords) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                instr_req_i,
    input  logic [31:0]         instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [31:0]         instr_rdata_o,
    output logic                instr_err_o,
    input  logic                stall_i,
    output logic                mem_req_o,
    output logic [AddrW-1:0]    mem_addr_o,
    input  logic [31:0]         mem_rdata_i,
    output logic [ImemCntW-1:0] outstanding_o
);

    localparam logic [32:0]          WinBytes = 33'(MemWords) << 2;
    localparam logic [ImemCntW-1:0]  MaxOut   = ImemCntW'(MaxOutstanding);

    logic [31:0]         offset;
    logic                in_range;
    logic                retire;
    logic                ctrl_valid_q;
    logic                ctrl_err_q;
    logic [ImemCntW-1:0] cnt_q, cnt_d;
    imem_resp_t          resp_t1;
    imem_resp_t          resp_out;

    assign offset   = instr_addr_i - MemBase;
    assign in_range = imem_in_window(offset, WinBytes);
    assign retire   = resp_out.valid;

    // A retiring response frees its slot in the same cycle, so a full window can still grant.
    assign instr_gnt_o = instr_req_i & ~stall_i & ~rst_i & ((cnt_q < MaxOut) | retire);
    assign mem_req_o   = instr_gnt_o & in_range;
    assign mem_addr_o  = mem_req_o ? offset[AddrW+1:2] : '0;

    always_comb begin
        cnt_d = cnt_q;
        if (instr_gnt_o && !retire) begin
            cnt_d = cnt_q + ImemCntW'(1);
        end else if (!instr_gnt_o && retire) begin
            cnt_d = cnt_q - ImemCntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_valid_q <= 1'b0;
            ctrl_err_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            ctrl_valid_q <= instr_gnt_o;
            ctrl_err_q   <= instr_gnt_o & ~in_range;
            cnt_q        <= cnt_d;
        end
    end

    // Response as seen one cycle after grant, when the SRAM data is valid.
    always_comb begin
        resp_t1       = '0;
        resp_t1.valid = ctrl_valid_q;
        resp_t1.err   = ctrl_valid_q & ctrl_err_q;
        if (ctrl_valid_q && !ctrl_err_q) begin
            resp_t1.rdata = mem_rdata_i;
        end
    end

    if (RespLatency <= 1) begin : g_lat1
        assign resp_out = resp_t1;
    end else begin : g_pipe
        ibex_imem_resp_pipe #(
            .Depth (RespLatency - 1)
        ) u_resp_pipe (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .resp_i (resp_t1),
            .resp_o (resp_out)
        );
    end

    assign instr_rvalid_o = resp_out.valid;
    assign instr_err_o    = resp_out.valid & resp_out.err;
    assign instr_rdata_o  = resp_out.valid ? resp_out.rdata : 32'h0;
    assign outstanding_o  = cnt_q;

endmodule

// File: tb/tb_ibex_imem_responder.sv
// Directed bench: four responder configurations share stimulus; each test resets and
// checks only the configuration it targets against hand-computed values.
module tb_ibex_imem_responder;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        stall;

    int n_cmp;
    int n_bad;

    // d0: defaults, d3: L3/M2, d4: L4/M2, d1: L1/M1
    logic        gnt0, rv0, er0, mr0;
    logic [31:0] rd0, sr0;
    logic [11:0] ma0;
    logic [2:0]  os0;
    logic        gnt3, rv3, er3, mr3;
    logic [31:0] rd3, sr3;
    logic [11:0] ma3;
    logic [2:0]  os3;
    logic        gnt4, rv4, er4, mr4;
    logic [31:0] rd4, sr4;
    logic [11:0] ma4;
    logic [2:0]  os4;
    logic        gnt1, rv1, er1, mr1;
    logic [31:0] rd1, sr1;
    logic [11:0] ma1;
    logic [2:0]  os1;

    ibex_imem_responder u_d0 (
        .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt0), .instr_rvalid_o(rv0), .instr_rdata_o(rd0), .instr_err_o(er0),
        .stall_i(stall), .mem_req_o(mr0), .mem_addr_o(ma0), .mem_rdata_i(sr0),
        .outstanding_o(os0)
    );

    ibex_imem_responder #(.RespLatency(3), .MaxOutstanding(2)) u_d3 (
        .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt3), .instr_rvalid_o(rv3), .instr_rdata_o(rd3), .instr_err_o(er3),
        .stall_i(stall), .mem_req_o(mr3), .mem_addr_o(ma3), .mem_rdata_i(sr3),
        .outstanding_o(os3)
    );

    ibex_imem_responder #(.RespLatency(4), .MaxOutstanding(2)) u_d4 (
        .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt4), .instr_rvalid_o(rv4), .instr_rdata_o(rd4), .instr_err_o(er4),
        .stall_i(stall), .mem_req_o(mr4), .mem_addr_o(ma4), .mem_rdata_i(sr4),
        .outstanding_o(os4)
    );

    ibex_imem_responder #(.RespLatency(1), .MaxOutstanding(1)) u_d1 (
        .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt1), .instr_rvalid_o(rv1), .instr_rdata_o(rd1), .instr_err_o(er1),
        .stall_i(stall), .mem_req_o(mr1), .mem_addr_o(ma1), .mem_rdata_i(sr1),
        .outstanding_o(os1)
    );

    function automatic logic [31:0] word(input logic [11:0] a);
        return (a == 12'h040) ? 32'h0000_0013 : (32'hC0DE_0000 | {20'h0, a});
    endfunction

    // SRAM models: data valid the cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        sr0 <= mr0 ? word(ma0) : 32'hDEAD_BEEF;
        sr3 <= mr3 ? word(ma3) : 32'hDEAD_BEEF;
        sr4 <= mr4 ? word(ma4) : 32'hDEAD_BEEF;
        sr1 <= mr1 ? word(ma1) : 32'hDEAD_BEEF;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        req   = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req  = 1'b1;
        addr = 32'h100;
        #1;
        n_cmp += 7;
        if (gnt0 !== 1'b0) begin n_bad++; $display("FAIL rst_gnt got %b want 0", gnt0); end
        if (mr0 !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req got %b want 0", mr0); end
        if (ma0 !== 12'h0) begin n_bad++; $display("FAIL rst_mem_addr got %h want 0", ma0); end
        if (rv0 !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid got %b want 0", rv0); end
        if (rd0 !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", rd0); end
        if (er0 !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", er0); end
        if (os0 !== 3'd0) begin n_bad++; $display("FAIL rst_outstanding got %0d want 0", os0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req  = 1'b1;
        addr = 32'h100;
        #1;
        n_cmp += 4;
        if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt_c0 got %b want 1", gnt0); end
        if (mr0 !== 1'b1) begin n_bad++; $display("FAIL b2b_memreq_c0 got %b want 1", mr0); end
        if (ma0 !== 12'h040) begin n_bad++; $display("FAIL b2b_memaddr_c0 got %h want 040", ma0); end
        if (rv0 !== 1'b0) begin n_bad++; $display("FAIL b2b_rvalid_c0 got %b want 0", rv0); end
        @(negedge clk);
        addr = 32'h104;
        #1;
        n_cmp += 6;
        if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt_c1 got %b want 1", gnt0); end
        if (ma0 !== 12'h041) begin n_bad++; $display("FAIL b2b_memaddr_c1 got %h want 041", ma0); end
        if (rv0 !== 1'b1) begin n_bad++; $display("FAIL b2b_rvalid_c1 got %b want 1", rv0); end
        if (rd0 !== 32'h13) begin n_bad++; $display("FAIL b2b_rdata_c1 got %h want 13", rd0); end
        if (er0 !== 1'b0) begin n_bad++; $display("FAIL b2b_err_c1 got %b want 0", er0); end
        if (os0 !== 3'd1) begin n_bad++; $display("FAIL b2b_os_c1 got %0d want 1", os0); end
        @(negedge clk);
        req = 1'b0;
        #1;
        n_cmp += 4;
        if (gnt0 !== 1'b0) begin n_bad++; $display("FAIL b2b_gnt_c2 got %b want 0", gnt0); end
        if (rv0 !== 1'b1) begin n_bad++; $display("FAIL b2b_rvalid_c2 got %b want 1", rv0); end
        if (rd0 !== 32'hC0DE_0041) begin
            n_bad++; $display("FAIL b2b_rdata_c2 got %h want c0de0041", rd0);
        end
        if (os0 !== 3'd1) begin n_bad++; $display("FAIL b2b_os_c2 got %0d want 1", os0); end
        @(negedge clk);
        #1;
        n_cmp += 4;
        if (rv0 !== 1'b0) begin n_bad++; $display("FAIL b2b_rvalid_c3 got %b want 0", rv0); end
        if (rd0 !== 32'h0) begin n_bad++; $display("FAIL b2b_rdata_idle got %h want 0", rd0); end
        if (er0 !== 1'b0) begin n_bad++; $display("FAIL b2b_err_idle got %b want 0", er0); end
        if (os0 !== 3'd0) begin n_bad++; $display("FAIL b2b_os_c3 got %0d want 0", os0); end
    endtask

    task automatic test_out_of_range();
        do_reset();
        req  = 1'b1;
        addr = 32'h0000_4000;
        #1;
        n_cmp += 3;
        if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL oor_gnt got %b want 1", gnt0); end
        if (mr0 !== 1'b0) begin n_bad++; $display("FAIL oor_memreq got %b want 0", mr0); end
        if (ma0 !== 12'h0) begin n_bad++; $display("FAIL oor_memaddr got %h want 0", ma0); end
        @(negedge clk);
        addr = 32'h0000_3FFC;
        #1;
        n_cmp += 5;
        if (rv0 !== 1'b1) begin n_bad++; $display("FAIL oor_rvalid got %b want 1", rv0); end
        if (er0 !== 1'b1) begin n_bad++; $display("FAIL oor_err got %b want 1", er0); end
        if (rd0 !== 32'h0) begin n_bad++; $display("FAIL oor_rdata got %h want 0", rd0); end
        if (mr0 !== 1'b1) begin n_bad++; $display("FAIL top_memreq got %b want 1", mr0); end
        if (ma0 !== 12'hFFF) begin n_bad++; $display("FAIL top_memaddr got %h want fff", ma0); end
        @(negedge clk);
        req = 1'b0;
        #1;
        n_cmp += 3;
        if (er0 !== 1'b0) begin n_bad++; $display("FAIL top_err got %b want 0", er0); end
        if (rd0 !== 32'hC0DE_0FFF) begin
            n_bad++; $display("FAIL top_rdata got %h want c0de0fff", rd0);
        end
        if (rv0 !== 1'b1) begin n_bad++; $display("FAIL top_rvalid got %b want 1", rv0); end
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1'b1;
        req   = 1'b1;
        addr  = 32'h100;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 2) addr = 32'h108;
            #1;
            n_cmp += 2;
            if (gnt0 !== 1'b0) begin n_bad++; $display("FAIL stall_gnt_c%0d got %b want 0", c, gnt0); end
            if (mr0 !== 1'b0) begin n_bad++; $display("FAIL stall_memreq_c%0d got %b want 0", c, mr0); end
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        n_cmp += 2;
        if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL stall_release_gnt got %b want 1", gnt0); end
        if (ma0 !== 12'h042) begin n_bad++; $display("FAIL stall_memaddr got %h want 042", ma0); end
        @(negedge clk);
        req = 1'b0;
        #1;
        n_cmp += 2;
        if (rv0 !== 1'b1) begin n_bad++; $display("FAIL stall_rvalid got %b want 1", rv0); end
        if (rd0 !== 32'hC0DE_0042) begin
            n_bad++; $display("FAIL stall_rdata got %h want c0de0042", rd0);
        end
    endtask

    task automatic test_latency_limit();
        int gexp [9] = '{1, 1, 0, 1, 1, 0, 1, 1, 0};
        int vexp [9] = '{0, 0, 0, 1, 1, 0, 1, 1, 0};
        int oexp [9] = '{0, 1, 2, 2, 2, 2, 2, 2, 2};
        logic [31:0] dexp;
        do_reset();
        req  = 1'b1;
        addr = 32'h200;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            dexp = (vexp[c] != 0) ? 32'hC0DE_0080 : 32'h0;
            n_cmp += 4;
            if (gnt3 !== 1'(gexp[c])) begin
                n_bad++; $display("FAIL lat3_gnt_c%0d got %b want %0d", c, gnt3, gexp[c]);
            end
            if (rv3 !== 1'(vexp[c])) begin
                n_bad++; $display("FAIL lat3_rvalid_c%0d got %b want %0d", c, rv3, vexp[c]);
            end
            if (os3 !== 3'(oexp[c])) begin
                n_bad++; $display("FAIL lat3_os_c%0d got %0d want %0d", c, os3, oexp[c]);
            end
            if (rd3 !== dexp) begin
                n_bad++; $display("FAIL lat3_rdata_c%0d got %h want %h", c, rd3, dexp);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req  = 1'b1;
        addr = 32'h100;
        #1;
        n_cmp++;
        if (gnt4 !== 1'b1) begin n_bad++; $display("FAIL mid_gnt_c0 got %b want 1", gnt4); end
        @(negedge clk);
        #1;
        n_cmp += 2;
        if (gnt4 !== 1'b1) begin n_bad++; $display("FAIL mid_gnt_c1 got %b want 1", gnt4); end
        if (os4 !== 3'd1) begin n_bad++; $display("FAIL mid_os_c1 got %0d want 1", os4); end
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        #1;
        n_cmp += 2;
        if (os4 !== 3'd0) begin n_bad++; $display("FAIL mid_os_rst got %0d want 0", os4); end
        if (rv4 !== 1'b0) begin n_bad++; $display("FAIL mid_rvalid_rst got %b want 0", rv4); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_cmp += 2;
            if (rv4 !== 1'b0) begin n_bad++; $display("FAIL mid_rvalid_c%0d got %b want 0", c, rv4); end
            if (os4 !== 3'd0) begin n_bad++; $display("FAIL mid_os_c%0d got %0d want 0", c, os4); end
            @(negedge clk);
        end
    endtask

    task automatic test_retire_and_grant();
        logic [31:0] dexp;
        do_reset();
        req = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            addr = 32'h100 + 32'(c * 4);
            #1;
            dexp = (c == 0) ? 32'h0 : word(12'(32'h3F + c));
            n_cmp += 4;
            if (gnt1 !== 1'b1) begin n_bad++; $display("FAIL m1_gnt_c%0d got %b want 1", c, gnt1); end
            if (os1 !== ((c == 0) ? 3'd0 : 3'd1)) begin
                n_bad++; $display("FAIL m1_os_c%0d got %0d want %0d", c, os1, (c == 0) ? 0 : 1);
            end
            if (rv1 !== (c != 0)) begin
                n_bad++; $display("FAIL m1_rvalid_c%0d got %b want %b", c, rv1, c != 0);
            end
            if (rd1 !== dexp) begin
                n_bad++; $display("FAIL m1_rdata_c%0d got %h want %h", c, rd1, dexp);
            end
        end
        req = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        req   = 1'b0;
        stall = 1'b0;
        addr  = 32'h0;
        test_reset();
        test_back_to_back();
        test_out_of_range();
        test_stall();
        test_latency_limit();
        test_reset_midflight();
        test_retire_and_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ibex_imem_responder.md
IBEX_IMEM_RESPONDER -- requirements
Module: ibex_imem_responder

Interface
REQ-001 Parameter MemBase, default 32'h0000_0000: byte base address of the responder window.
REQ-002 Parameter MemWords, default 4096: window size in 32-bit words; SHALL be a power of two.
REQ-003 Parameter RespLatency, default 1, legal range 1..4: cycles from grant to rvalid.
REQ-004 Parameter MaxOutstanding, default 2, legal range 1..4: maximum granted-but-unanswered requests.
REQ-005 clk_i  in  1  sole clock; all state on rising edge.
REQ-006 rst_i  in  1  reset, asynchronous assert, active-high.
REQ-007 instr_req_i  in  1  fetch request from initiator.
REQ-008 instr_addr_i  in  32  fetch byte address; bits [1:0] ignored.
REQ-009 instr_gnt_o  out  1  request accepted this cycle.
REQ-010 instr_rvalid_o  out  1  response valid, single-cycle pulse per grant.
REQ-011 instr_rdata_o  out  32  response data.
REQ-012 instr_err_o  out  1  response error; qualified by instr_rvalid_o.
REQ-013 stall_i  in  1  test hook; forces instr_gnt_o low.
REQ-014 mem_req_o  out  1  SRAM read strobe.
REQ-015 mem_addr_o  out  log2(MemWords)  SRAM word address.
REQ-016 mem_rdata_i  in  32  SRAM read data, valid the cycle after mem_req_o.
REQ-017 outstanding_o  out  3  current outstanding count.

Function
REQ-018 instr_gnt_o SHALL be combinational: instr_req_i & ~stall_i & ~rst_i & (outstanding < MaxOutstanding | a response retires this cycle).
REQ-019 In-range SHALL mean (instr_addr_i - MemBase) < MemWords*4, computed as unsigned 32-bit.
REQ-020 On a granted in-range request: mem_req_o=1 in the grant cycle, with mem_addr_o = (instr_addr_i - MemBase) >> 2.
REQ-021 On a granted out-of-range request: mem_req_o SHALL stay 0.
REQ-022 The grant in cycle t SHALL produce instr_rvalid_o=1 in exactly cycle t+RespLatency.
REQ-023 With RespLatency=1, instr_rdata_o SHALL pass mem_rdata_i through combinationally.
REQ-024 With RespLatency>1, mem_rdata_i SHALL be captured at t+1 and shifted through RespLatency-1 register stages.
REQ-025 An out-of-range response SHALL have instr_err_o=1 and instr_rdata_o=0; an in-range response SHALL have instr_err_o=0.
REQ-026 While instr_rvalid_o=0, instr_rdata_o and instr_err_o SHALL be 0.
REQ-027 Responses SHALL be strictly in grant order; there is no rvalid backpressure.
REQ-028 Outstanding accounting: +1 on grant, -1 on rvalid, unchanged when both occur in the same cycle; the count SHALL never exceed MaxOutstanding.
REQ-029 If MaxOutstanding >= RespLatency, the block SHALL sustain one grant per cycle; otherwise it SHALL throttle via gnt without losing requests.
REQ-030 An address change while instr_req_i is high and ungranted SHALL be accepted; only the address present at grant is used.

Reset
REQ-031 While rst_i=1: instr_gnt_o, instr_rvalid_o, instr_err_o, mem_req_o = 0; instr_rdata_o, mem_addr_o = 0; outstanding_o = 0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight responses; none SHALL appear after deassertion.
REQ-033 The first grant SHALL be possible in the first clock edge after rst_i falls.

Structure
REQ-034 A response struct {valid, err, rdata[31:0]} SHALL be defined in ibex_pkg as imem_resp_t.
REQ-035 The latency shift register SHALL be the sub-module ibex_imem_resp_pipe, parameterised by depth and carrying imem_resp_t.
REQ-036 The SRAM itself is external; this block contains no storage array.

Verification
REQ-037 Back-to-back fetches (defaults; SRAM word 0x40 = 32'h0000_0013; req at 0x100, then 0x104): gnt in cycles 0 and 1; rvalid in cycles 1 and 2; rdata 32'h0000_0013 first.
REQ-038 Out-of-range fetch (req at 0x0000_4000): gnt=1, mem_req_o=0; next cycle rvalid=1, err=1, rdata=0.
REQ-039 Latency limit (RespLatency=3, MaxOutstanding=2, continuous req): gnt pattern 1,1,0,1,1,0...; outstanding_o never exceeds 2.
REQ-040 Stall (stall_i=1 for 5 cycles with req held): gnt=0 throughout; grant in the first cycle after stall_i falls; response one cycle later.
REQ-041 Reset mid-flight (RespLatency=4; two grants, then rst_i pulsed at cycle 2): no rvalid at any cycle after reset; outstanding_o=0.
REQ-042 Simultaneous retire and grant (MaxOutstanding=1, RespLatency=1, continuous req): gnt every cycle; outstanding_o stays 1.
